// File: rtl/rope_pkg.sv
// rope_pkg
// Shared types and constants for the rope segment streamer.
//   COORD_W        : width of one packed Q16.16 node coordinate
//   FRAC_W_DEFAULT : default number of fractional coordinate bits
//   stream_state_t : streamer FSM state encoding
//   segment_t      : registered segment (fields sized for the widest
//                    supported pixel / index widths; the top slices them)
package rope_pkg;

  localparam int COORD_W        = 32;
  localparam int FRAC_W_DEFAULT = 16;
  localparam int SEG_PIX_W      = 16;
  localparam int SEG_IDX_W      = 16;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } stream_state_t;

  typedef struct packed {
    logic [SEG_PIX_W-1:0] x0;
    logic [SEG_PIX_W-1:0] y0;
    logic [SEG_PIX_W-1:0] x1;
    logic [SEG_PIX_W-1:0] y1;
    logic [SEG_IDX_W-1:0] idx;
    logic                 last;
  } segment_t;

endpackage

// File: rtl/rope_coord_to_pixel.sv
// rope_coord_to_pixel
// Converts one signed Q16.16 coordinate to an integer pixel coordinate.
// Build option: ROPE_SEGMENT_CLIP_EN clamps the result to [0, BOUND-1];
// without it the integer part is truncated and wraps.
// Ports:
//   coord : in  COORD_W  signed fixed-point coordinate
//   pix   : out PIX_W    pixel coordinate
module rope_coord_to_pixel
  import rope_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEFAULT,
  parameter int PIX_W  = 11,
  parameter int BOUND  = 640
) (
  input  logic signed [COORD_W-1:0] coord,
  output logic        [PIX_W-1:0]   pix
);

`ifdef ROPE_SEGMENT_CLIP_EN
  logic signed [COORD_W-1:0] ipart;

  // Clamp on the full signed integer part, not on the truncated bits.
  always_comb begin
    ipart = coord >>> FRAC_W;
    if (coord < 0)
      pix = '0;
    else if (ipart >= BOUND)
      pix = PIX_W'(BOUND - 1);
    else
      pix = coord[FRAC_W+PIX_W-1:FRAC_W];
  end
`else
  // Arithmetic floor of the fixed-point value; upper bits simply wrap.
  assign pix = coord[FRAC_W+PIX_W-1:FRAC_W];
`endif

endmodule

// File: rtl/rope_segment_streamer.sv
// rope_segment_streamer
// Snapshots all rope node coordinates on frame_tick and streams consecutive
// node pairs as pixel-space line segments over a valid/ready interface.
// Build option: ROPE_SEGMENT_CLIP_EN enables screen clamping of coordinates.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   frame_tick           : request to snapshot and stream one frame
//   nodes_x, nodes_y     : packed node coordinates, node k at [32k+31:32k]
//   seg_valid/seg_ready  : segment handshake
//   seg_x0/y0, seg_x1/y1 : segment endpoints (node idx, node idx+1)
//   seg_idx, seg_last    : segment index, final-segment flag
//   busy                 : high while streaming
//   drop_count           : saturating count of ticks ignored while streaming
//
// state  | meaning
// IDLE   | waiting for frame_tick; segment outputs hold last values
// STREAM | presenting segment seg_idx until accepted
module rope_segment_streamer
  import rope_pkg::*;
#(
  parameter int NODE_COUNT = 10,
  parameter int FRAC_W     = FRAC_W_DEFAULT,
  parameter int PIX_W      = 11,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [NODE_COUNT*32-1:0]      nodes_x,
  input  logic [NODE_COUNT*32-1:0]      nodes_y,
  output logic                          seg_valid,
  input  logic                          seg_ready,
  output logic [PIX_W-1:0]              seg_x0,
  output logic [PIX_W-1:0]              seg_y0,
  output logic [PIX_W-1:0]              seg_x1,
  output logic [PIX_W-1:0]              seg_y1,
  output logic [$clog2(NODE_COUNT)-1:0] seg_idx,
  output logic                          seg_last,
  output logic                          busy,
  output logic [7:0]                    drop_count
);

  localparam int IDX_W = $clog2(NODE_COUNT);
  localparam int VEC_W = NODE_COUNT * COORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODE_COUNT - 2);
  localparam logic [IDX_W-1:0] TOP_NODE = IDX_W'(NODE_COUNT - 1);

  stream_state_t state_q, state_d;
  segment_t      seg_q;
  logic [VEC_W-1:0]   snap_x_q, snap_y_q;
  logic [7:0]         drop_q;
  logic               load_first, load_next, finish;
  logic [IDX_W-1:0]   idx_cur, idx_next, sel_a, sel_b;
  logic [VEC_W-1:0]   src_x, src_y;
  logic [COORD_W-1:0] ax, ay, bx, by;
  logic [PIX_W-1:0]   px0, py0, px1, py1;

  assign idx_cur  = seg_q.idx[IDX_W-1:0];
  assign idx_next = idx_cur + 1'b1;

  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    load_next  = 1'b0;
    finish     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          state_d    = STREAM;
          load_first = 1'b1;
        end
      end
      STREAM: begin
        if (seg_ready) begin
          if (idx_cur == LAST_IDX) begin
            state_d = IDLE;
            finish  = 1'b1;
          end else begin
            load_next = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The first segment comes straight from the live inputs (the snapshot is
  // captured on the same edge); later segments come from the snapshot.
  // sel_b is clamped so the mux index stays in range even when unused.
  assign src_x = (state_q == IDLE) ? nodes_x : snap_x_q;
  assign src_y = (state_q == IDLE) ? nodes_y : snap_y_q;
  assign sel_a = (state_q == IDLE) ? '0 : idx_next;
  assign sel_b = (sel_a == TOP_NODE) ? sel_a : sel_a + 1'b1;

  assign ax = src_x[sel_a*COORD_W +: COORD_W];
  assign ay = src_y[sel_a*COORD_W +: COORD_W];
  assign bx = src_x[sel_b*COORD_W +: COORD_W];
  assign by = src_y[sel_b*COORD_W +: COORD_W];

  rope_coord_to_pixel #(.FRAC_W(FRAC_W), .PIX_W(PIX_W), .BOUND(SCREEN_W)) u_cvt_x0 (
    .coord($signed(ax)), .pix(px0));
  rope_coord_to_pixel #(.FRAC_W(FRAC_W), .PIX_W(PIX_W), .BOUND(SCREEN_H)) u_cvt_y0 (
    .coord($signed(ay)), .pix(py0));
  rope_coord_to_pixel #(.FRAC_W(FRAC_W), .PIX_W(PIX_W), .BOUND(SCREEN_W)) u_cvt_x1 (
    .coord($signed(bx)), .pix(px1));
  rope_coord_to_pixel #(.FRAC_W(FRAC_W), .PIX_W(PIX_W), .BOUND(SCREEN_H)) u_cvt_y1 (
    .coord($signed(by)), .pix(py1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      seg_q    <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_first) begin
        snap_x_q <= nodes_x;
        snap_y_q <= nodes_y;
      end
      if (load_first || load_next) begin
        seg_q.x0   <= SEG_PIX_W'(px0);
        seg_q.y0   <= SEG_PIX_W'(py0);
        seg_q.x1   <= SEG_PIX_W'(px1);
        seg_q.y1   <= SEG_PIX_W'(py1);
        seg_q.idx  <= load_first ? '0 : SEG_IDX_W'(idx_next);
        seg_q.last <= load_first ? (NODE_COUNT == 2) : (idx_next == LAST_IDX);
      end else if (finish) begin
        seg_q.last <= 1'b0;
      end
      if ((state_q == STREAM) && frame_tick && (drop_q != 8'hFF))
        drop_q <= drop_q + 1'b1;
    end
  end

  assign seg_valid  = (state_q == STREAM);
  assign busy       = (state_q == STREAM);
  assign seg_x0     = seg_q.x0[PIX_W-1:0];
  assign seg_y0     = seg_q.y0[PIX_W-1:0];
  assign seg_x1     = seg_q.x1[PIX_W-1:0];
  assign seg_y1     = seg_q.y1[PIX_W-1:0];
  assign seg_idx    = idx_cur;
  assign seg_last   = seg_q.last;
  assign drop_count = drop_q;

endmodule
